rpn_stack_file: RTL and testbench

Parametrised operand stack for the RPN calculator datapath. It is the next generation of the fixed 8×16 load-enable register file: depth and width are parameters, and it adds stack addressing with push/pop/swap/dup/binary-op commands, occupancy tracking, sticky overflow/underflow flags and an indexed read port. It sits between the keypad/command decoder and the ALU. The ALU consumes `top` and `next`, and its result returns on `data_in` with a BINOP command.

---
 rtl/rpn_stack_file.sv | 247 ++++++++++++++++++++++++
 tb/tb_rpn_stack_file.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_file.sv
// -----------------------------------------------------------------------------
// rpn_stack_file
//
// Operand stack for the RPN calculator datapath. It sits between the command
// decoder and the ALU: the ALU reads `top`/`next`, and its result comes back
// on `data_in` with a BINOP command.
//
// Storage is D = 2^n words of k bits plus an (n+1)-bit stack pointer that
// equals the number of valid entries. The entry at depth i lives at
// mem[sp-1-i]. Entries are never shifted; only the pointer moves.
//
// Ports
//   clk      in   1    rising-edge clock
//   reset    in   1    synchronous active-high reset (pointer and flags only)
//   cmd      in   3    000 NOP, 001 PUSH, 010 POP, 011 REPLACE,
//                      100 BINOP, 101 SWAP, 110 DUP, 111 CLEAR
//   data_in  in   k    operand for PUSH / REPLACE / BINOP
//   rd_idx   in   n    indexed read depth (0 = top)
//   top      out  k    depth 0, zero when count < 1
//   next     out  k    depth 1, zero when count < 2
//   rd_data  out  k    depth rd_idx, zero when rd_idx >= count
//   count    out  n+1  number of valid entries, 0..D
//   empty    out  1    count == 0
//   full     out  1    count == D
//   ovf      out  1    sticky: PUSH or DUP attempted while full
//   unf      out  1    sticky: POP/REPLACE/BINOP/SWAP with too few entries
// -----------------------------------------------------------------------------
module rpn_stack_file #(
    parameter int k = 16,
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   cmd,
    input  logic [k-1:0] data_in,
    input  logic [n-1:0] rd_idx,
    output logic [k-1:0] top,
    output logic [k-1:0] next,
    output logic [k-1:0] rd_data,
    output logic [n:0]   count,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int D = 1 << n;

    localparam logic [n:0]   DEPTH   = (n+1)'(D);
    localparam logic [n:0]   SP_ONE  = (n+1)'(1);
    localparam logic [n:0]   SP_TWO  = (n+1)'(2);
    localparam logic [n-1:0] IDX_ONE = n'(1);
    localparam logic [n-1:0] IDX_TWO = n'(2);

    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_PUSH    = 3'b001;
    localparam logic [2:0] CMD_POP     = 3'b010;
    localparam logic [2:0] CMD_REPLACE = 3'b011;
    localparam logic [2:0] CMD_BINOP   = 3'b100;
    localparam logic [2:0] CMD_SWAP    = 3'b101;
    localparam logic [2:0] CMD_DUP     = 3'b110;
    localparam logic [2:0] CMD_CLEAR   = 3'b111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [k-1:0] mem_q [D];
    logic [n:0]   sp_q, sp_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    // ------------------------------------------------------------------
    // Address arithmetic
    //
    // Indices are computed modulo D on the low n pointer bits. When the
    // stack is full the low bits wrap to 0, so sp-1 still lands on D-1;
    // the pointer's MSB is only needed for occupancy comparisons.
    // ------------------------------------------------------------------
    logic [n-1:0] sp_lo;
    logic [n-1:0] top_idx;
    logic [n-1:0] next_idx;
    logic [n-1:0] rd_mem_idx;

    assign sp_lo      = sp_q[n-1:0];
    assign top_idx    = sp_lo - IDX_ONE;
    assign next_idx   = sp_lo - IDX_TWO;
    assign rd_mem_idx = sp_lo - IDX_ONE - rd_idx;

    // Occupancy predicates used by both legality checks and outputs.
    logic has1, has2, is_full, rd_ok;

    assign has1    = (sp_q != '0);
    assign has2    = (sp_q >= SP_TWO);
    assign is_full = (sp_q == DEPTH);
    assign rd_ok   = ({1'b0, rd_idx} < sp_q);

    // ------------------------------------------------------------------
    // Command decode
    //
    // Two write ports are enough for every command: SWAP needs both to
    // exchange top and next in one cycle, everything else uses port A.
    // An illegal command leaves pointer and memory untouched and only
    // raises the relevant sticky flag.
    // ------------------------------------------------------------------
    logic         we_a, we_b;
    logic [n-1:0] addr_a, addr_b;
    logic [k-1:0] data_a, data_b;

    always_comb begin
        sp_d   = sp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        we_a   = 1'b0;
        addr_a = sp_lo;
        data_a = data_in;
        we_b   = 1'b0;
        addr_b = next_idx;
        data_b = mem_q[top_idx];

        case (cmd)
            CMD_NOP: begin
            end

            CMD_PUSH: begin
                if (!is_full) begin
                    we_a   = 1'b1;
                    addr_a = sp_lo;
                    data_a = data_in;
                    sp_d   = sp_q + SP_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end

            CMD_POP: begin
                if (has1) begin
                    sp_d = sp_q - SP_ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end

            CMD_REPLACE: begin
                if (has1) begin
                    we_a   = 1'b1;
                    addr_a = top_idx;
                    data_a = data_in;
                end else begin
                    unf_d = 1'b1;
                end
            end

            // Net effect of "pop two, push result": result overwrites the
            // old next slot and the pointer drops by one.
            CMD_BINOP: begin
                if (has2) begin
                    we_a   = 1'b1;
                    addr_a = next_idx;
                    data_a = data_in;
                    sp_d   = sp_q - SP_ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end

            CMD_SWAP: begin
                if (has2) begin
                    we_a   = 1'b1;
                    addr_a = top_idx;
                    data_a = mem_q[next_idx];
                    we_b   = 1'b1;
                    addr_b = next_idx;
                    data_b = mem_q[top_idx];
                end else begin
                    unf_d = 1'b1;
                end
            end

            // DUP on an empty stack is an underflow-free no-op only in the
            // sense that full takes precedence; an empty DUP is simply
            // ignored since neither flag condition names it.
            CMD_DUP: begin
                if (has1 && !is_full) begin
                    we_a   = 1'b1;
                    addr_a = sp_lo;
                    data_a = mem_q[top_idx];
                    sp_d   = sp_q + SP_ONE;
                end else if (is_full) begin
                    ovf_d = 1'b1;
                end
            end

            CMD_CLEAR: begin
                sp_d  = '0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end

            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers: pointer and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // ------------------------------------------------------------------
    // Data storage: not reset. Writes are suppressed during reset so a
    // command issued alongside reset has no effect at all.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (we_a) begin
                mem_q[addr_a] <= data_a;
            end
            if (we_b) begin
                mem_q[addr_b] <= data_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: purely combinational from registered state (and rd_idx).
    // Slots above the pointer are masked to zero.
    // ------------------------------------------------------------------
    assign top     = has1  ? mem_q[top_idx]    : '0;
    assign next    = has2  ? mem_q[next_idx]   : '0;
    assign rd_data = rd_ok ? mem_q[rd_mem_idx] : '0;
    assign count   = sp_q;
    assign empty   = !has1;
    assign full    = is_full;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_rpn_stack_file.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_file
//
// Directed testbench for rpn_stack_file with k=16, n=3 (D=8). Every
// expected value below is hand-derived from the stack semantics.
// -----------------------------------------------------------------------------
module tb_rpn_stack_file;

    localparam int K = 16;
    localparam int N = 3;

    localparam logic [2:0] C_NOP     = 3'b000;
    localparam logic [2:0] C_PUSH    = 3'b001;
    localparam logic [2:0] C_POP     = 3'b010;
    localparam logic [2:0] C_REPLACE = 3'b011;
    localparam logic [2:0] C_BINOP   = 3'b100;
    localparam logic [2:0] C_SWAP    = 3'b101;
    localparam logic [2:0] C_DUP     = 3'b110;
    localparam logic [2:0] C_CLEAR   = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   cmd;
    logic [K-1:0] data_in;
    logic [N-1:0] rd_idx;
    logic [K-1:0] top;
    logic [K-1:0] next;
    logic [K-1:0] rd_data;
    logic [N:0]   count;
    logic         empty;
    logic         full;
    logic         ovf;
    logic         unf;

    rpn_stack_file #(.k(K), .n(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd),
        .data_in (data_in),
        .rd_idx  (rd_idx),
        .top     (top),
        .next    (next),
        .rd_data (rd_data),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one command for one clock edge, then settle 1 time unit past
    // the edge so outputs are sampled away from it.
    task automatic do_cmd(input logic [2:0] c, input logic [K-1:0] d);
        cmd     = c;
        data_in = d;
        @(posedge clk);
        #1;
        cmd     = C_NOP;
        data_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        cmd     = C_NOP;
        data_in = '0;
        rd_idx  = '0;
        do_cmd(C_NOP, '0);
        do_cmd(C_NOP, '0);
        reset = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_top",   32'(top),   32'd0);
        chk("rst_next",  32'(next),  32'd0);
        chk("rst_rd",    32'(rd_data), 32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_unf",   32'(unf),   32'd0);

        // Two pushes
        do_cmd(C_PUSH, 16'h0003);
        do_cmd(C_PUSH, 16'h0004);
        chk("p2_count", 32'(count), 32'd2);
        chk("p2_top",   32'(top),   32'h0004);
        chk("p2_next",  32'(next),  32'h0003);
        chk("p2_empty", 32'(empty), 32'd0);
        rd_idx = 3'd1;
        #1;
        chk("p2_rd1", 32'(rd_data), 32'h0003);
        rd_idx = 3'd0;

        // BINOP then SWAP underflow
        do_cmd(C_BINOP, 16'h0007);
        chk("bin_count", 32'(count), 32'd1);
        chk("bin_top",   32'(top),   32'h0007);
        chk("bin_next",  32'(next),  32'd0);
        do_cmd(C_SWAP, '0);
        chk("swp_unf",   32'(unf),   32'd1);
        chk("swp_top",   32'(top),   32'h0007);
        chk("swp_count", 32'(count), 32'd1);

        // Fill to D, then overflow attempts
        do_cmd(C_CLEAR, '0);
        chk("clr_unf",   32'(unf),   32'd0);
        chk("clr_count", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_cmd(C_PUSH, 16'h0011 + 16'(i));
            if (i == 6) begin
                chk("fill7_count", 32'(count), 32'd7);
                chk("fill7_full",  32'(full),  32'd0);
            end
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_top",   32'(top),   32'h0018);
        chk("fill_ovf",   32'(ovf),   32'd0);
        do_cmd(C_PUSH, 16'h00FF);
        chk("ovp_ovf",   32'(ovf),   32'd1);
        chk("ovp_top",   32'(top),   32'h0018);
        do_cmd(C_DUP, '0);
        chk("ovd_ovf",   32'(ovf),   32'd1);
        chk("ovd_count", 32'(count), 32'd8);
        chk("ovd_top",   32'(top),   32'h0018);
        chk("ovd_next",  32'(next),  32'h0017);
        rd_idx = 3'd7;
        #1;
        chk("full_rd7", 32'(rd_data), 32'h0011);
        rd_idx = 3'd3;
        #1;
        chk("full_rd3", 32'(rd_data), 32'h0015);
        rd_idx = 3'd0;

        // Drain, then underflow: both flags must hold together
        for (int i = 0; i < 7; i++) begin
            do_cmd(C_POP, '0);
        end
        chk("drain_count", 32'(count), 32'd1);
        chk("drain_top",   32'(top),   32'h0011);
        do_cmd(C_POP, '0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_unf0",  32'(unf),   32'd0);
        do_cmd(C_POP, '0);
        chk("both_unf",   32'(unf),   32'd1);
        chk("both_ovf",   32'(ovf),   32'd1);
        chk("both_count", 32'(count), 32'd0);

        // SWAP / DUP / REPLACE
        do_cmd(C_CLEAR, '0);
        chk("clr2_ovf", 32'(ovf), 32'd0);
        chk("clr2_unf", 32'(unf), 32'd0);
        do_cmd(C_PUSH, 16'h00A1);
        do_cmd(C_PUSH, 16'h00B2);
        do_cmd(C_SWAP, '0);
        chk("sw_top",  32'(top),  32'h00A1);
        chk("sw_next", 32'(next), 32'h00B2);
        do_cmd(C_DUP, '0);
        chk("dup_count", 32'(count), 32'd3);
        chk("dup_top",   32'(top),   32'h00A1);
        chk("dup_next",  32'(next),  32'h00A1);
        do_cmd(C_REPLACE, 16'h0055);
        chk("rep_top",   32'(top),   32'h0055);
        chk("rep_next",  32'(next),  32'h00A1);
        chk("rep_count", 32'(count), 32'd3);
        rd_idx = 3'd2;
        #1;
        chk("rep_rd2", 32'(rd_data), 32'h00B2);
        rd_idx = 3'd3;
        #1;
        chk("rep_rd3_oob", 32'(rd_data), 32'd0);
        rd_idx = 3'd0;
        do_cmd(C_POP, '0);
        chk("pop_count", 32'(count), 32'd2);
        chk("pop_top",   32'(top),   32'h00A1);

        // POP on empty, then CLEAR, indexed read on empty stack
        do_cmd(C_CLEAR, '0);
        do_cmd(C_POP, '0);
        chk("ep_unf",   32'(unf),   32'd1);
        chk("ep_count", 32'(count), 32'd0);
        do_cmd(C_CLEAR, '0);
        chk("ec_unf", 32'(unf), 32'd0);
        chk("ec_ovf", 32'(ovf), 32'd0);
        rd_idx = 3'd2;
        #1;
        chk("ec_rd2", 32'(rd_data), 32'd0);
        rd_idx = 3'd0;

        // Reset overrides a same-cycle PUSH and clears a set flag
        do_cmd(C_PUSH, 16'h0099);
        do_cmd(C_REPLACE, 16'h0000);
        do_cmd(C_BINOP, 16'h0001);
        chk("pre_unf", 32'(unf), 32'd1);
        reset = 1'b1;
        do_cmd(C_PUSH, 16'h1234);
        reset = 1'b0;
        chk("rp_count", 32'(count), 32'd0);
        chk("rp_top",   32'(top),   32'd0);
        chk("rp_unf",   32'(unf),   32'd0);
        chk("rp_ovf",   32'(ovf),   32'd0);
        do_cmd(C_PUSH, 16'h1234);
        chk("ap_count", 32'(count), 32'd1);
        chk("ap_top",   32'(top),   32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
